// File: rtl/cpu_pkg.sv
// cpu_pkg - types and constants shared by the memory port arbiter files.
//   arb_state_t : arbiter FSM states (IDLE, RD_WAIT)
//   ARB_ID_I    : port ID of the instruction fetch port
//   ARB_ID_D    : port ID of the load/store data port
package cpu_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  localparam logic ARB_ID_I = 1'b0;
  localparam logic ARB_ID_D = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// arb_pick - combinational 2-way picker between the fetch and data ports.
// Build option: ARB_ROUND_ROBIN_EN
//   defined   : round-robin; on a tie the port that did not win last goes
//   undefined : fixed priority, data port over fetch port
// Ports:
//   i_req     in   fetch port is requesting
//   d_req     in   data port is requesting
//   last_id   in   port ID of the most recent grant (round-robin only)
//   win_id    out  port ID of the chosen requester
//   win_valid out  at least one port is requesting
module arb_pick
  import cpu_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_id,
  output logic win_id,
  output logic win_valid
);

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin choice: a tie goes to the port not granted last time.
  always_comb begin
    win_valid = i_req | d_req;
    if (i_req && d_req) begin
      win_id = (last_id == ARB_ID_I) ? ARB_ID_D : ARB_ID_I;
    end else if (d_req) begin
      win_id = ARB_ID_D;
    end else begin
      win_id = ARB_ID_I;
    end
  end
`else
  // The last-grant flag has no meaning under fixed priority.
  logic last_id_unused;
  assign last_id_unused = last_id;

  // Fixed priority: the data access belongs to an older instruction, so it
  // goes first; the fetch port may starve while stores stream.
  always_comb begin
    win_valid = i_req | d_req;
    if (d_req) begin
      win_id = ARB_ID_D;
    end else begin
      win_id = ARB_ID_I;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter - shares one single-port synchronous RAM between the
// instruction fetch port (read-only) and the load/store port (read/write).
// Grants are combinational in the cycle the arbiter is idle; stores finish in
// the grant cycle, reads wait MEM_LAT cycles and return data with an rvalid
// pulse. Arbitration policy is chosen by ARB_ROUND_ROBIN_EN (see arb_pick).
// Parameters: AW address width (word index), DW data width, MEM_LAT read
// latency 1..7.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_req/i_addr                   fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata         fetch accept pulse, data valid pulse, data
//   d_req/d_we/d_addr/d_wdata/d_be data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata         data accept pulse, load valid pulse, data
//   m_en/m_we/m_addr/m_wdata/m_be  memory command
//   m_rdata                        memory read data
//   busy                           arbiter is waiting on a read
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DW-1:0]     i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  input  logic [DW/8-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  output logic [DW/8-1:0]   m_be,
  input  logic [DW-1:0]     m_rdata,
  output logic              busy
);

  localparam int CW = $clog2(MEM_LAT + 1);
  // Counter runs MEM_LAT-1 .. 0 while in RD_WAIT, so rvalid lands exactly
  // MEM_LAT cycles after the grant.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_id_q, rd_id_d;
  logic            last_id_q, last_id_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            pick_id;
  logic            pick_valid;

  arb_pick u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
    .last_id   (last_id_q),
    .win_id    (pick_id),
    .win_valid (pick_valid)
  );

  // Next-state and command logic; all strobes are held low during reset so
  // no access or rvalid can escape while rst is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_id_d   = rd_id_q;
    last_id_d = last_id_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_be      = '0;
    if (rst) begin
      state_d   = IDLE;
      cnt_d     = '0;
      rd_id_d   = ARB_ID_I;
      last_id_d = ARB_ID_I;
      i_rdata_d = '0;
      d_rdata_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            m_en      = 1'b1;
            last_id_d = pick_id;
            if (pick_id == ARB_ID_D) begin
              d_gnt  = 1'b1;
              m_addr = d_addr;
              m_we   = d_we;
              if (d_we) begin
                // Store completes in the grant cycle; stay IDLE.
                m_wdata = d_wdata;
                m_be    = d_be;
              end else begin
                state_d = RD_WAIT;
                cnt_d   = CNT_LOAD;
                rd_id_d = ARB_ID_D;
              end
            end else begin
              i_gnt   = 1'b1;
              m_addr  = i_addr;
              state_d = RD_WAIT;
              cnt_d   = CNT_LOAD;
              rd_id_d = ARB_ID_I;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            if (rd_id_q == ARB_ID_D) begin
              d_rvalid  = 1'b1;
              d_rdata_d = m_rdata;
            end else begin
              i_rvalid  = 1'b1;
              i_rdata_d = m_rdata;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Read data passes straight through on the rvalid cycle and holds after.
  assign i_rdata = i_rdata_d;
  assign d_rdata = d_rdata_d;
  assign busy    = (state_q != IDLE);

  // State, latency counter, winner/last-grant IDs and held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_id_q   <= ARB_ID_I;
      last_id_q <= ARB_ID_I;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_id_q   <= rd_id_d;
      last_id_q <= last_id_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter - self-checking bench for mem_port_arbiter.
// Main DUT uses MEM_LAT = 2; a second instance with MEM_LAT = 1 covers the
// back-to-back fetch case. A transaction-level model (outstanding-read
// countdown, reference RAM image, last-winner flag) predicts every cycle.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_en, m_we, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  logic        i2_req, i2_gnt, i2_rvalid, d2_gnt, d2_rvalid;
  logic [31:0] i2_addr, i2_rdata, d2_rdata;
  logic        m2_en, m2_we, busy2;
  logic [31:0] m2_addr, m2_wdata, m2_rdata;
  logic [3:0]  m2_be;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .i_req(i2_req), .i_addr(i2_addr), .i_gnt(i2_gnt), .i_rvalid(i2_rvalid), .i_rdata(i2_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
    .d_gnt(d2_gnt), .d_rvalid(d2_rvalid), .d_rdata(d2_rdata),
    .m_en(m2_en), .m_we(m2_we), .m_addr(m2_addr), .m_wdata(m2_wdata), .m_be(m2_be),
    .m_rdata(m2_rdata), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: byte-masked writes, 2-stage read pipe for the main DUT,
  // 1-stage pipe for the MEM_LAT=1 instance.
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] pipe1, pipe2, pipe_b;
  always @(posedge clk) begin
    if (m_en && m_we)
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[5:0]][8*b +: 8] <= m_wdata[8*b +: 8];
    if (m_en && !m_we) pipe1 <= mem[m_addr[5:0]];
    pipe2 <= pipe1;
    if (m2_en && !m2_we) pipe_b <= mem[m2_addr[5:0]];
  end
  assign m_rdata  = pipe2;
  assign m2_rdata = pipe_b;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int          m_wait = 0;      // cycles until the outstanding read returns
  logic        m_port = 1'b0;   // 1 = data port owns the outstanding read
  logic [31:0] m_data = '0;     // data that read will return
  logic        m_last = 1'b0;   // last granted port, 1 = data
  logic [31:0] m_ir = '0, m_dr = '0;
  int          cyc = 0, iv_cnt = 0, t6_cyc = -1;
  logic        saw_ig, saw_dg, saw_dv;

  // One clock: predict and compare at negedge, then advance past posedge.
  task automatic step();
    logic e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_busy, win_d;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    @(negedge clk);
    e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_en = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wd = '0; e_be = '0;
    saw_ig = i_gnt; saw_dg = d_gnt; saw_dv = d_rvalid;
    if (i_rvalid) iv_cnt++;
    if (rst) begin
      check("rst_strobes", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_en}, 5'b0);
      m_wait = 0; m_last = 1'b0; m_ir = '0; m_dr = '0;
    end else begin
      e_busy = (m_wait > 0);
      if (m_wait > 0) begin
        if (m_wait == 1) begin
          if (m_port) begin e_dv = 1'b1; m_dr = m_data; end
          else        begin e_iv = 1'b1; m_ir = m_data; end
        end
        m_wait--;
      end else if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = d_req && (!i_req || !m_last);
`else
        win_d = d_req;
`endif
        m_last = win_d;
        e_en = 1'b1;
        if (win_d) begin
          e_dg = 1'b1; e_addr = d_addr; e_we = d_we;
          if (d_we) begin
            e_wd = d_wdata; e_be = d_be;
            for (int b = 0; b < 4; b++)
              if (d_be[b]) ref_mem[d_addr[5:0]][8*b +: 8] = d_wdata[8*b +: 8];
          end else begin
            m_wait = LAT; m_port = 1'b1; m_data = ref_mem[d_addr[5:0]];
          end
        end else begin
          e_ig = 1'b1; e_addr = i_addr;
          m_wait = LAT; m_port = 1'b0; m_data = ref_mem[i_addr[5:0]];
        end
      end
      check("ctl{ig,dg,iv,dv,en,we,busy}", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, busy},
            {e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_busy});
      check("i_rdata", i_rdata, m_ir);
      check("d_rdata", d_rdata, m_dr);
      if (e_en) check("m_addr", m_addr, e_addr);
      if (e_we) begin
        check("m_wdata", m_wdata, e_wd);
        check("m_be", m_be, e_be);
      end
    end
    if (t6_cyc >= 0) begin
      check("t6_gnt", i2_gnt, (t6_cyc == 0 || t6_cyc == 2));
      check("t6_rvalid", i2_rvalid, (t6_cyc == 1 || t6_cyc == 3));
      if (t6_cyc == 1 || t6_cyc == 2) check("t6_rdata", i2_rdata, 32'h11111111);
      if (t6_cyc == 3) check("t6_rdata", i2_rdata, 32'h22222222);
      t6_cyc = (t6_cyc == 3) ? -1 : t6_cyc + 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [4:0] T5_EXP = 5'b10101;
`else
  localparam logic [4:0] T5_EXP = 5'b11110;
`endif

  initial begin
    int base, first, ig_c, dv_c, nd, ng;
    logic [4:0] seq;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    i2_req = 1'b0; i2_addr = '0;
    for (int k = 0; k < 64; k++) begin mem[k] = '0; ref_mem[k] = '0; end
    mem[0] = 32'h11111111; ref_mem[0] = 32'h11111111;
    mem[1] = 32'h22222222; ref_mem[1] = 32'h22222222;
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    repeat (3) step();
    rst = 1'b0;

    // MEM_LAT=1 back-to-back fetches of 0x0 and 0x1
    i2_req = 1'b1; i2_addr = 32'h0; t6_cyc = 0;
    step();
    i2_addr = 32'h1;
    step(); step();
    i2_req = 1'b0;
    step();

    // Reset one cycle after a fetch grant: the read must vanish
    i_req = 1'b1; i_addr = 32'h10;
    step();
    i_req = 1'b0; rst = 1'b1; base = iv_cnt;
    step();
    rst = 1'b0;
    repeat (4) step();
    check("t1_no_rvalid", iv_cnt - base, 0);

    // Lone fetch of word 4
    i_req = 1'b1; i_addr = 32'h4;
    step();
    i_req = 1'b0;
    step(); step();
    check("t2_rdata", i_rdata, 32'hDEADBEEF);

    // Partial store, then load back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h12345678; d_be = 4'b0011;
    step();
    d_req = 1'b0; d_we = 1'b0;
    step();
    d_req = 1'b1; d_addr = 32'h8;
    step();
    d_req = 1'b0;
    step(); step();
    check("t3_load", d_rdata, 32'h00005678);

    // Tie between fetch and load right after reset
    rst = 1'b1; step(); rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h5; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h9;
    first = -1; ig_c = -1; dv_c = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if ((saw_ig || saw_dg) && first < 0) first = saw_dg ? 1 : 0;
      if (saw_dv) dv_c = cyc;
      if (saw_ig) begin ig_c = cyc; i_req = 1'b0; end
      if (saw_dg) d_req = 1'b0;
    end
    check("t4_first_is_d", first, 1);
    check("t4_i_after_dvalid", ig_c - dv_c, 1);

    // Store streaming against a continuously fetching I-port
    rst = 1'b1; step(); rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h2;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = $urandom; d_be = 4'hF;
    nd = 0; ng = 0; seq = '0;
    for (int k = 0; k < 60; k++) begin
      step();
      if ((saw_ig || saw_dg) && ng < 5) begin seq = {seq[3:0], saw_dg}; ng++; end
      if (saw_dg) begin
        nd++;
        if (nd >= 4) d_req = 1'b0;
        else begin d_addr = 32'($urandom_range(16, 63)); d_wdata = $urandom; d_be = 4'($urandom_range(0, 15)); end
      end
      if (saw_ig) begin
        if (ng >= 5 && nd >= 4) i_req = 1'b0;
        else i_addr = 32'($urandom_range(0, 63));
      end
    end
    check("t5_grant_order", seq, T5_EXP);
    check("t5_store_count", nd, 4);
    check("t5_drained", {i_req, d_req, busy}, 3'b0);

    // Random traffic with aborts and occasional resets
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (saw_ig || !i_req) begin
        i_req = 1'($urandom_range(0, 1)); i_addr = 32'($urandom_range(0, 63));
      end else if ($urandom_range(0, 15) == 0) begin
        i_req = 1'b0;
      end else begin
        i_req = 1'b1;
      end
      if (saw_dg || !d_req) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 63)); d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end else begin
        d_req = 1'b1;
      end
      step();
    end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
